// File: rtl/accel_offchip_loader.sv
// Off-chip load sequencer: packs host words into one pixel row, then streams
// weight-2 rows into the weight-2 SRAM, pacing each later row on the accelerator's request.
module accel_offchip_loader #(
    parameter int PIX_W       = 9,
    parameter int PIX_PER_ROW = 10,
    parameter int W2_W        = 16,
    parameter int W2_DEPTH    = 16,
    parameter int N_W2_ROWS   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         host_valid,
    input  logic [15:0]                  host_data,
    output logic                         host_ready,
    input  logic                         weight2_loadNextRow,
    output logic                         inputSramWe,
    output logic [PIX_W*PIX_PER_ROW-1:0] pixels,
    output logic                         w2SramWeOffChip,
    output logic [W2_W-1:0]              weight2,
    output logic [$clog2(W2_DEPTH)-1:0]  weight2AddrOffChip,
    output logic                         busy,
    output logic                         done,
    output logic [4:0]                   row_count
);

    localparam int AW  = $clog2(W2_DEPTH);
    localparam int PCW = $clog2(PIX_PER_ROW);
    localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIX_PER_ROW - 1);
    localparam logic [AW-1:0]  WORD_LAST = AW'(W2_DEPTH - 1);
    localparam logic [4:0]     ROW_LAST  = 5'(N_W2_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PIX_COLLECT,
        PIX_WRITE,
        W2_LOAD,
        WAIT_NEXT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PCW-1:0] pix_cnt;
    logic [AW-1:0]  word_cnt;
    logic           pending;
    logic           xfer;

    always_comb begin
        xfer       = host_valid && host_ready;
        state_next = state;
        unique case (state)
            IDLE:        if (start) state_next = PIX_COLLECT;
            PIX_COLLECT: if (xfer && pix_cnt == PIX_LAST) state_next = PIX_WRITE;
            PIX_WRITE:   state_next = W2_LOAD;
            W2_LOAD: begin
                if (xfer && word_cnt == WORD_LAST)
                    state_next = (row_count == ROW_LAST) ? DONE : WAIT_NEXT;
            end
            WAIT_NEXT:   if (pending || weight2_loadNextRow) state_next = W2_LOAD;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Strobes and host_ready are registered decodes of the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_ready         <= 1'b0;
            inputSramWe        <= 1'b0;
            pixels             <= '0;
            w2SramWeOffChip    <= 1'b0;
            weight2            <= '0;
            weight2AddrOffChip <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            row_count          <= '0;
            pix_cnt            <= '0;
            word_cnt           <= '0;
            pending            <= 1'b0;
        end else begin
            host_ready      <= (state_next == PIX_COLLECT) || (state_next == W2_LOAD);
            inputSramWe     <= (state_next == PIX_WRITE);
            done            <= (state_next == DONE);
            w2SramWeOffChip <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        pix_cnt   <= '0;
                        row_count <= '0;
                    end
                end
                PIX_COLLECT: begin
                    if (xfer) begin
                        for (int unsigned k = 0; k < PIX_PER_ROW; k++) begin
                            if (pix_cnt == PCW'(k))
                                pixels[k*PIX_W +: PIX_W] <= host_data[PIX_W-1:0];
                        end
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                PIX_WRITE: begin
                    word_cnt <= '0;
                    pending  <= 1'b0;
                end
                W2_LOAD: begin
                    // An early request is remembered so the row boundary does not stall.
                    if (weight2_loadNextRow) pending <= 1'b1;
                    if (xfer) begin
                        w2SramWeOffChip    <= 1'b1;
                        weight2            <= host_data[W2_W-1:0];
                        weight2AddrOffChip <= word_cnt;
                        word_cnt           <= word_cnt + 1'b1;
                        if (word_cnt == WORD_LAST) begin
                            row_count <= row_count + 5'd1;
                            if (row_count == ROW_LAST) busy <= 1'b0;
                        end
                    end
                end
                WAIT_NEXT: begin
                    if (pending || weight2_loadNextRow) begin
                        pending  <= 1'b0;
                        word_cnt <= '0;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_offchip_loader.sv
// Randomized bench for accel_offchip_loader: the expected write streams, timing
// and row pacing are derived from the list of words the host actually handed over.
module tb_accel_offchip_loader;

    localparam int NR = 3;
    localparam int NW = 16 * NR;

    logic        clk = 1'b0;
    logic        reset, start, host_valid, weight2_loadNextRow;
    logic [15:0] host_data;
    logic        host_ready, inputSramWe, w2SramWeOffChip, busy, done;
    logic [89:0] pixels;
    logic [15:0] weight2;
    logic [3:0]  weight2AddrOffChip;
    logic [4:0]  row_count;

    always #5 clk = ~clk;

    accel_offchip_loader #(.N_W2_ROWS(NR)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .host_valid         (host_valid),
        .host_data          (host_data),
        .host_ready         (host_ready),
        .weight2_loadNextRow(weight2_loadNextRow),
        .inputSramWe        (inputSramWe),
        .pixels             (pixels),
        .w2SramWeOffChip    (w2SramWeOffChip),
        .weight2            (weight2),
        .weight2AddrOffChip (weight2AddrOffChip),
        .busy               (busy),
        .done               (done),
        .row_count          (row_count)
    );

    typedef struct packed {
        int          c;
        logic [3:0]  a;
        logic [15:0] d;
    } strobe_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int overlap;
    strobe_t     sq[$];
    int          acc_cyc[$];
    int          we_cyc[$];
    logic [89:0] we_pix[$];
    logic        we_rdy[$];
    int          done_cyc[$];
    logic [4:0]  bound_rc[$];
    logic        bound_busy[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        sq.delete(); acc_cyc.delete(); we_cyc.delete(); we_pix.delete();
        we_rdy.delete(); done_cyc.delete(); bound_rc.delete(); bound_busy.delete();
        overlap = 0;
    endtask

    // One clock: drive inputs, let the edge pass, record what the DUT shows.
    task automatic step(input logic hv, input logic [15:0] hd, input logic lnr, output logic fired);
        host_valid          = hv;
        host_data           = hd;
        weight2_loadNextRow = lnr;
        fired = hv && host_ready;
        @(posedge clk); #1;
        cyc++;
        if (fired) acc_cyc.push_back(cyc);
        if (w2SramWeOffChip) sq.push_back('{cyc, weight2AddrOffChip, weight2});
        if (inputSramWe) begin
            we_cyc.push_back(cyc); we_pix.push_back(pixels); we_rdy.push_back(host_ready);
        end
        if (done) done_cyc.push_back(cyc);
        if (w2SramWeOffChip && inputSramWe) overlap++;
    endtask

    task automatic drive_job(input logic [15:0] w[$], input int gap, input int er, input int en,
                             output logic finished);
        int idx, budget, wcnt, tog, rw, rk;
        logic f, hv, lnr;
        clear_logs();
        idx = 0; budget = 4000; wcnt = 0; tog = 1;
        start = 1'b1; step(1'b0, '0, 1'b0, f); start = 1'b0;
        while (idx < w.size() && budget > 0) begin
            budget--;
            if (gap == 0)      hv = 1'b1;
            else if (gap == 1) hv = (tog != 0);
            else               hv = ($urandom_range(0, 1) != 0);
            tog = 1 - tog;
            lnr = 1'b0;
            if (idx == 3 && hv && host_ready) lnr = 1'b1;
            if (idx >= 10) begin
                rw = (idx - 10) / 16;
                rk = (idx - 10) % 16;
                if (rw == er && hv && host_ready && (rk == 4 || (en == 2 && rk == 8))) lnr = 1'b1;
            end
            if (idx > 10 && (idx - 10) % 16 == 0 && !host_ready) begin
                wcnt++;
                if (wcnt == 1) begin bound_rc.push_back(row_count); bound_busy.push_back(busy); end
                if (wcnt == 3 && (idx - 10) / 16 - 1 != er) lnr = 1'b1;
            end
            step(hv, w[idx], lnr, f);
            if (f) begin idx++; wcnt = 0; end
        end
        finished = (idx == w.size());
        budget = 20;
        while (done_cyc.size() == 0 && budget > 0) begin budget--; step(1'b0, '0, 1'b0, f); end
        step(1'b0, '0, 1'b0, f);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = '0; weight2_loadNextRow = 1'b0;
        #23;
        checks++;
        if ({host_ready, inputSramWe, w2SramWeOffChip, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000",
                               {host_ready, inputSramWe, w2SramWeOffChip, busy, done});
        end
        checks++;
        if (pixels !== 90'b0) begin errors++; $display("FAIL reset_pixels got=%h want=0", pixels); end
        checks++;
        if ({weight2, weight2AddrOffChip, row_count} !== 25'b0) begin
            errors++; $display("FAIL reset_w2 got=%h want=0", {weight2, weight2AddrOffChip, row_count});
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_idle_ignore();
        logic f;
        clear_logs();
        for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'(i % 2), f);
        checks++;
        if (sq.size() != 0 || we_cyc.size() != 0 || done_cyc.size() != 0) begin
            errors++; $display("FAIL idle_strobes got=%0d want=0", sq.size() + we_cyc.size() + done_cyc.size());
        end
        checks++;
        if ({host_ready, busy} !== 2'b00) begin
            errors++; $display("FAIL idle_ready_busy got=%b want=00", {host_ready, busy});
        end
    endtask

    task automatic test_jobs(input int s0, input int s1);
        int gap_t[5] = '{0, 1, 0, 0, 2};
        int er_t[5]  = '{-1, -1, 0, 0, 1};
        int en_t[5]  = '{0, 0, 1, 2, 1};
        for (int s = s0; s <= s1; s++) begin
            logic [15:0] w[$];
            logic [89:0] exp_pix;
            logic        fin, bad;
            int          bi, g, eg, last;
            w = {};
            for (int k = 0; k < 10; k++)
                w.push_back(s == 0 ? 16'(k + 1) : (s == 1 ? 16'hFE05 : 16'($urandom)));
            for (int k = 0; k < NW; k++)
                w.push_back(s == 0 ? 16'(32'h1000 + (k / 16) * 256 + k % 16) : 16'($urandom));
            for (int k = 0; k < 10; k++) exp_pix[k*9 +: 9] = w[k][8:0];

            drive_job(w, gap_t[s], er_t[s], en_t[s], fin);

            checks++;
            if (!fin) begin errors++; $display("FAIL job_complete s=%0d got=%0d words want=%0d", s, acc_cyc.size(), w.size()); end
            if (fin) begin
                last = acc_cyc[w.size() - 1];
                checks++;
                if (we_cyc.size() != 1 || we_cyc[0] != acc_cyc[9] || we_pix[0] !== exp_pix || we_rdy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL pix_write s=%0d got n=%0d cyc=%0d rdy=%b pix=%h want n=1 cyc=%0d rdy=0 pix=%h",
                             s, we_cyc.size(), we_cyc.size() > 0 ? we_cyc[0] : -1,
                             we_rdy.size() > 0 ? we_rdy[0] : 1'bx, we_pix.size() > 0 ? we_pix[0] : 90'bx, acc_cyc[9], exp_pix);
                end
                checks++;
                if (sq.size() != NW) begin errors++; $display("FAIL strobe_count s=%0d got=%0d want=%0d", s, sq.size(), NW); end
                bad = 1'b0; bi = 0;
                for (int i = 0; i < sq.size() && i < NW; i++) begin
                    if (!bad && (sq[i].c != acc_cyc[10+i] || sq[i].a !== 4'(i % 16) || sq[i].d !== w[10+i])) begin
                        bad = 1'b1; bi = i;
                    end
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL strobe_data s=%0d i=%0d got cyc=%0d a=%0h d=%h want cyc=%0d a=%0h d=%h",
                             s, bi, sq[bi].c, sq[bi].a, sq[bi].d, acc_cyc[10+bi], 4'(bi % 16), w[10+bi]);
                end
                checks++;
                if (done_cyc.size() != 1 || done_cyc[0] != last) begin
                    errors++; $display("FAIL done_pulse s=%0d got n=%0d cyc=%0d want n=1 cyc=%0d",
                                       s, done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, last);
                end
                checks++;
                if ({busy, done, host_ready} !== 3'b000 || row_count !== 5'(NR) || pixels !== exp_pix) begin
                    errors++; $display("FAIL job_end s=%0d got bdr=%b rows=%0d want bdr=000 rows=%0d",
                                       s, {busy, done, host_ready}, row_count, NR);
                end
                checks++;
                if (overlap != 0) begin errors++; $display("FAIL we_overlap s=%0d got=%0d want=0", s, overlap); end
                checks++;
                if (bound_rc.size() != NR - 1) begin
                    errors++; $display("FAIL row_waits s=%0d got=%0d want=%0d", s, bound_rc.size(), NR - 1);
                end
                for (int b = 0; b < bound_rc.size(); b++) begin
                    checks++;
                    if (bound_rc[b] !== 5'(b + 1) || bound_busy[b] !== 1'b1) begin
                        errors++; $display("FAIL row_count_wait s=%0d b=%0d got=%0d busy=%b want=%0d busy=1",
                                           s, b, bound_rc[b], bound_busy[b], b + 1);
                    end
                end
                if (gap_t[s] == 0) begin
                    for (int b = 0; b < NR - 1; b++) begin
                        g  = acc_cyc[10 + 16*(b+1)] - acc_cyc[9 + 16*(b+1)];
                        eg = (b == er_t[s]) ? 2 : 4;
                        checks++;
                        if (g != eg) begin errors++; $display("FAIL row_gap s=%0d b=%0d got=%0d want=%0d", s, b, g, eg); end
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic f;
        int n, b;
        clear_logs();
        start = 1'b1; step(1'b0, '0, 1'b0, f); start = 1'b0;
        n = 0; b = 200;
        while (n < 18 && b > 0) begin
            b--;
            step(1'b1, n < 10 ? 16'($urandom) : 16'(32'h2000 + n - 10), 1'b0, f);
            if (f) n++;
        end
        checks++;
        if (n != 18 || w2SramWeOffChip !== 1'b1 || weight2AddrOffChip !== 4'd7 || weight2 !== 16'h2007) begin
            errors++; $display("FAIL word7_strobe got n=%0d we=%b a=%0h d=%h want n=18 we=1 a=7 d=2007",
                               n, w2SramWeOffChip, weight2AddrOffChip, weight2);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({host_ready, inputSramWe, w2SramWeOffChip, busy, done} !== 5'b0 || pixels !== 90'b0 ||
            {weight2, weight2AddrOffChip, row_count} !== 25'b0) begin
            errors++; $display("FAIL async_reset got ctrl=%b w2=%h a=%0h rows=%0d want all 0",
                               {host_ready, inputSramWe, w2SramWeOffChip, busy, done}, weight2, weight2AddrOffChip, row_count);
        end
        step(1'b1, '0, 1'b0, f);
        step(1'b1, '0, 1'b0, f);
        #2 reset = 1'b1;
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), f);
        checks++;
        if (sq.size() != 0 || we_cyc.size() != 0 || done_cyc.size() != 0 || {host_ready, busy} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle got strobes=%0d rdy_busy=%b want 0 00",
                               sq.size() + we_cyc.size() + done_cyc.size(), {host_ready, busy});
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_jobs(0, 3);
        test_async_reset();
        test_jobs(4, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accel_offchip_loader.md
Name: accel_offchip_loader

Overview:
Host-side load sequencer that drives the accelerator's off-chip load interface. It accepts a 16-bit word stream from the host over a valid/ready handshake and packs 10 words into one 90-bit pixel row, writing it with a one-cycle inputSramWe pulse. It then writes weight-2 rows word by word into the weight-2 SRAM. Each row after the first is loaded only when the accelerator raises weight2_loadNextRow.

Parameters:
PIX_W, 9, bits per pixel
PIX_PER_ROW, 10, pixels per pixel row (pixels width = PIX_W*PIX_PER_ROW = 90)
W2_W, 16, weight-2 word width
W2_DEPTH, 16, words per weight-2 row (address width 4)
N_W2_ROWS, 16, weight-2 rows per job

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a job; sampled only in IDLE
host_valid  input  1  host_data is valid
host_data  input  16  host word; bits [8:0] used in the pixel phase
host_ready  output  1  loader accepts host_data this cycle
weight2_loadNextRow  input  1  accelerator request for the next weight-2 row (pulse)
inputSramWe  output  1  pixel-row write strobe
pixels  output  90  packed pixel row
w2SramWeOffChip  output  1  weight-2 SRAM write strobe / off-chip address select
weight2  output  16  weight-2 write data
weight2AddrOffChip  output  4  weight-2 write address
busy  output  1  job in progress
done  output  1  one-cycle end-of-job pulse
row_count  output  5  completed weight-2 rows in the current job

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, all counters 0, pending flag 0. Reset mid-job aborts the job without any further write strobes.
- Handshake: a transfer occurs on a rising edge with host_valid&&host_ready. host_ready is a registered state decode: 1 only in PIX_COLLECT and W2_LOAD. host_data is ignored when no transfer occurs.
- States:
  - IDLE: start=1 -> PIX_COLLECT, busy=1, pixel counter=0, row_count=0.
  - PIX_COLLECT: the k-th transfer (k=0..9) writes host_data[8:0] to pixels[9k+8:9k]; bits [15:9] are discarded. The transfer at k=9 -> PIX_WRITE.
  - PIX_WRITE: one cycle. inputSramWe=1, host_ready=0, pixels stable. -> W2_LOAD, word counter=0, pending cleared.
  - W2_LOAD: each transfer registers, on the next cycle, w2SramWeOffChip=1, weight2=host_data, weight2AddrOffChip=word counter; the counter then increments. The strobe lasts exactly one cycle per transfer, and back-to-back transfers give back-to-back strobes. The 16th transfer (counter=15) increments row_count. If row_count becomes N_W2_ROWS -> DONE, otherwise -> WAIT_NEXT. The final strobe is issued in the first cycle of the next state.
  - WAIT_NEXT: host_ready=0. If pending or weight2_loadNextRow=1 -> W2_LOAD, clearing pending and the word counter.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Pending flag: set by weight2_loadNextRow=1 in W2_LOAD, so an early request is never lost. Multiple pulses collapse to one. Pulses in IDLE, PIX_COLLECT, PIX_WRITE and DONE are ignored.
- Output holds:
  - pixels holds its value until the next job overwrites it; its partial contents during PIX_COLLECT are don't-care to the consumer.
  - weight2 and weight2AddrOffChip hold their last written value while w2SramWeOffChip=0.
  - w2SramWeOffChip and inputSramWe are never 1 in the same cycle.
- start while busy=1 is ignored. start and reset release in the same cycle: reset wins.
- Latency:
  - last pixel transfer at edge t -> inputSramWe=1 in cycle t+1.
  - weight word transfer at edge t -> write strobe in cycle t+1.
  - final row's last transfer at edge t -> done in cycle t+1, coinciding with the last strobe.

Test Plan:
- Pixel pack: start; send 0x0001..0x000A with host_valid held high -> 10 transfers, then one cycle of inputSramWe=1 with pixels[8:0]=1 and pixels[89:81]=10; host_ready=0 that cycle.
- Upper-bit discard: pixel words 0xFE05 -> each 9-bit field = 0x005.
- Weight row: after the pixel row, send 0x1000..0x100F back to back -> 16 consecutive strobe cycles with addr 0..15 and data 0x1000+addr; then WAIT_NEXT with host_ready=0 and row_count=1.
- Early request: pulse weight2_loadNextRow during the 5th word of a row -> row completes, then W2_LOAD is entered immediately with no further pulse. Two early pulses -> only one extra row is enabled.
- Full job with N_W2_ROWS=2, host_valid toggling every other cycle -> 32 strobes total; done=1 for exactly one cycle together with the final strobe; busy falls; row_count=2.
- Async reset asserted mid-row at word 7 -> all outputs 0 immediately, without waiting for a clock edge. After release, state is IDLE and no strobe is issued until start.
